// File: rtl/fetch_stage_pkg.sv
// Shared RV32I fetch definitions: reset PC, NOP encoding, instruction field
// positions and the (pc, instr) bundle carried from fetch to decode.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int F3_LSB  = 12;
  localparam int F3_W    = 3;
  localparam int F7_LSB  = 25;
  localparam int F7_W    = 7;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_stage_queue.sv
// fetch_queue: in-order synchronous FIFO for fetch bundles. A flush in the
// same cycle as a push leaves exactly the pushed entry in the queue.
module fetch_queue #(
  parameter int             DEPTH   = 2,
  parameter int             W       = 64,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= push ? AW'(1) : '0;
      r_cnt <= push ? (AW+1)'(1) : '0;
      if (push) r_mem[0] <= push_data;
    end else begin
      if (push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = r_mem[r_rd];
  assign full  = (r_cnt == (AW+1)'(DEPTH));
  assign empty = (r_cnt == '0);
  assign count = r_cnt;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, credit-limited imem requests, bundle queue.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect emits a flagged NOP and halts fetch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7
`ifdef FETCH_ALIGN_CHECK_EN
  ,output logic       id_misaligned
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam int QW = $bits(fetch_bundle_t) + 1;
`else
  localparam int QW = $bits(fetch_bundle_t);
`endif

  logic          r_active;
  logic [31:0]   r_pc, r_rsp_pc;
  logic [CW-1:0] r_outst, r_drop;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_credit;
  logic          w_full, w_empty, w_halt, w_mis_redir;
  logic          w_pop, w_push, w_enq, w_req_fire, w_drop_rsp;
  logic [31:0]   w_redir_pc;
  fetch_bundle_t w_push_b, w_head_b;
  logic [QW-1:0] w_push_d, w_head_d;

  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_pop      = id_valid & id_ready & ~redirect_valid;

  // A bundle leaving the queue this cycle frees a slot for a request issued now.
  assign w_credit = {1'b0, r_outst} + {1'b0, w_count} - {{CW{1'b0}}, id_valid & id_ready};
  assign imem_req_valid = r_active & ~redirect_valid & ~w_halt
                        & (w_credit < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_drop_rsp = imem_rsp_valid & (r_drop != '0);
  assign w_enq      = imem_rsp_valid & (r_drop == '0) & ~redirect_valid & (~w_full | w_pop);
  assign w_push     = w_enq | w_mis_redir;

  assign w_push_b.pc    = w_mis_redir ? redirect_pc : r_rsp_pc;
  assign w_push_b.instr = w_mis_redir ? NOP_INSTR   : imem_rsp_data;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_halt;
  assign w_mis_redir = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign w_halt      = r_halt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_halt <= 1'b0;
    else if (redirect_valid) r_halt <= w_mis_redir;
  end
  assign w_push_d      = {w_mis_redir, w_push_b};
  assign w_head_b      = w_head_d[$bits(fetch_bundle_t)-1:0];
  assign id_misaligned = w_head_d[QW-1];
`else
  assign w_mis_redir = 1'b0;
  assign w_halt      = 1'b0;
  assign w_push_d    = w_push_b;
  assign w_head_b    = w_head_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outst  <= '0;
      r_drop   <= '0;
    end else begin
      r_active <= 1'b1;
      if (redirect_valid) begin
        // Everything still in flight belongs to the abandoned path.
        r_pc     <= w_redir_pc;
        r_rsp_pc <= w_redir_pc;
        r_outst  <= r_outst - CW'(imem_rsp_valid);
        r_drop   <= r_outst - CW'(imem_rsp_valid);
      end else begin
        if (w_req_fire) r_pc     <= r_pc + 32'd4;
        if (w_enq)      r_rsp_pc <= r_rsp_pc + 32'd4;
        if (w_drop_rsp) r_drop   <= r_drop - CW'(1);
        r_outst <= r_outst + CW'(w_req_fire) - CW'(imem_rsp_valid);
      end
    end
  end

  fetch_queue #(
    .DEPTH   (FIFO_DEPTH),
    .W       (QW),
    .RST_VAL (QW'({RESET_PC, 32'h0000_0000}))
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_d),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head      (w_head_d),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign id_valid  = ~w_empty;
  assign id_pc     = w_head_b.pc;
  assign id_instr  = w_head_b.instr;
  assign id_opcode = w_head_b.instr[OPC_LSB +: OPC_W];
  assign id_funct3 = w_head_b.instr[F3_LSB +: F3_W];
  assign id_funct7 = w_head_b.instr[F7_LSB +: F7_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: epoch-tagged memory model plus an expected
// bundle queue, checked every cycle. Covers FETCH_ALIGN_CHECK_EN when defined.
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_pc, id_instr;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        id_misaligned;
  localparam logic [31:0] AMASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RD2   = 32'h0000_0300;
`else
  localparam logic [31:0] AMASK = 32'hFFFF_FFFF;
  localparam logic [31:0] RD2   = 32'h0000_0301;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7)
`ifdef FETCH_ALIGN_CHECK_EN
    , .id_misaligned(id_misaligned)
`endif
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } bun_t;

  mreq_t       mem[$];
  bun_t        mq[$];
  logic [31:0] popped[$];
  logic        popped_mis[$];
  logic [31:0] fpc, mis_instr;
  logic [6:0]  op4, f7_4;
  logic [2:0]  f3_4;
  int          epoch, cyc, last_due, lat, p_ready, p_idr, first_vld, n_fire;
  int          n_chk, n_fail;
  bit          halted;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0093;
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [31:0] pget(input int i);
    return (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_id_valid",  32'(id_valid), 32'h0);
    chk("rst_id_pc",     id_pc, 32'h0);
    chk("rst_id_instr",  id_instr, 32'h0);
    chk("rst_fields",    {12'h0, id_funct7, id_funct3, 3'h0, id_opcode}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_misaligned", 32'(id_misaligned), 32'h0);
`endif
    mem.delete(); mq.delete();
    fpc = '0; epoch = 0; cyc = 0; last_due = -1; halted = 1'b0; first_vld = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: compare outputs with the model, drive inputs, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc);
    bun_t  e;
    mreq_t m;
    bit    rsp_now, pop, fire, exp_rv;
    int    occ;
    @(negedge clk);
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      e = mq[0];
      if (first_vld < 0) first_vld = cyc;
      chk("id_pc", id_pc, e.pc);
      chk("id_instr", id_instr, e.instr);
      chk("id_opcode", 32'(id_opcode), 32'(e.instr[6:0]));
      chk("id_funct3", 32'(id_funct3), 32'(e.instr[14:12]));
      chk("id_funct7", 32'(id_funct7), 32'(e.instr[31:25]));
`ifdef FETCH_ALIGN_CHECK_EN
      chk("id_misaligned", 32'(id_misaligned), 32'(e.mis));
`endif
    end
    rsp_now = (mem.size() != 0) && (mem[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? memf(mem[0].addr) : $urandom;
    imem_req_ready = (int'($urandom_range(99)) < p_ready);
    id_ready       = (int'($urandom_range(99)) < p_idr);
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    pop    = (mq.size() != 0) && id_ready && !redir;
    occ    = mem.size() + mq.size() - ((mq.size() != 0 && id_ready) ? 1 : 0);
    exp_rv = !redir && !halted && (occ < DEPTH);
    chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (imem_req_valid) chk("imem_req_addr", imem_req_addr, fpc);
    fire = imem_req_valid && imem_req_ready;
    if (pop) begin
      popped.push_back(mq[0].pc);
      popped_mis.push_back(mq[0].mis);
      if (mq[0].pc == 32'h4) begin op4 = id_opcode; f3_4 = id_funct3; f7_4 = id_funct7; end
      if (mq[0].mis) mis_instr = id_instr;
    end
    if (rsp_now) m = mem.pop_front();
    if (redir) begin
      epoch++;
      mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      halted = (rpc[1:0] != 2'b00);
      if (halted) mq.push_back('{pc: rpc, instr: 32'h0000_0013, mis: 1'b1});
`endif
      fpc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(mq.pop_front());
      if (rsp_now && m.epoch == epoch) mq.push_back('{pc: m.addr, instr: memf(m.addr), mis: 1'b0});
      if (fire) begin
        last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        mem.push_back('{addr: fpc, epoch: epoch, due: last_due});
        fpc += 32'd4;
        n_fire++;
      end
    end
    cyc++;
  endtask

  initial begin
    int k, f0;
    n_chk = 0; n_fail = 0; n_fire = 0; lat = 1; p_ready = 100; p_idr = 100;
    op4 = '1; f3_4 = '1; f7_4 = '1; mis_instr = '0;
    do_reset();

    // Streaming from reset with a 1-cycle memory
    repeat (12) step(1'b0, '0);
    chk("first_valid_cycle", 32'(first_vld), 32'd2);
    chk("throughput_pops", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 4; i++) chk("inorder_pc", pget(i), 32'(i * 4));
    chk("opcode_addi", 32'(op4), 32'h13);
    chk("funct3_addi", 32'(f3_4), 32'h0);
    chk("funct7_addi", 32'(f7_4), 32'h0);

    // Decode stall for 5 cycles
    p_idr = 0; f0 = n_fire;
    repeat (5) step(1'b0, '0);
    chk("stall_no_requests", 32'(n_fire - f0), 32'd0);
    popped.delete(); p_idr = 100;
    repeat (8) step(1'b0, '0);
    chk("stall_release_pc0", pget(0), 32'h28);
    chk("stall_release_pc2", pget(2), 32'h30);

    // Redirect with two requests in flight
    lat = 3; k = 0;
    while (!(mem.size() == 2 && mem[0].epoch == epoch && mem[1].epoch == epoch) && k < 30) begin
      step(1'b0, '0); k++;
    end
    chk("found_two_outstanding", 32'(k < 30), 32'h1);
    popped.delete();
    step(1'b1, 32'h100);
    repeat (12) step(1'b0, '0);
    chk("redirect_first_pc", pget(0), 32'h100);
    chk("redirect_second_pc", pget(1), 32'h104);

    // Redirect coinciding with a response and a pop
    lat = 1; k = 0;
    while (!(mem.size() != 0 && mem[0].due <= cyc && mem[0].epoch == epoch && mq.size() != 0) && k < 30) begin
      step(1'b0, '0); k++;
    end
    chk("found_rsp_pop_cycle", 32'(k < 30), 32'h1);
    popped.delete();
    step(1'b1, RD2);
    repeat (8) step(1'b0, '0);
    chk("redirect_rsp_pop_pc", pget(0), 32'h300);

    // Reset mid-operation, then randomized traffic and redirects
    lat = 3; p_ready = 60;
    repeat (4) step(1'b0, '0);
    do_reset();
    lat = 3; p_ready = 50; p_idr = 70;
    for (int i = 0; i < 600; i++) step($urandom_range(49) == 0, $urandom & AMASK);
    lat = 2; p_ready = 80; p_idr = 50;
    for (int i = 0; i < 600; i++) step($urandom_range(39) == 0, $urandom & AMASK);

`ifdef FETCH_ALIGN_CHECK_EN
    lat = 1; p_ready = 100; p_idr = 100;
    popped.delete(); popped_mis.delete();
    step(1'b1, 32'h102);
    f0 = n_fire;
    repeat (10) step(1'b0, '0);
    chk("misalign_pc", pget(0), 32'h102);
    chk("misalign_flag", 32'(popped_mis.size() != 0 && popped_mis[0]), 32'h1);
    chk("misalign_instr", mis_instr, 32'h13);
    chk("misalign_single", 32'(popped.size()), 32'd1);
    chk("misalign_no_fetch", 32'(n_fire - f0), 32'd0);
    step(1'b1, 32'h200);
    repeat (8) step(1'b0, '0);
    chk("resume_pc", pget(1), 32'h200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
